// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: PC owner + instruction FIFO feeding the LEGv8 decode stage
// Ports: clock/reset (sync, active-high); rom_address/rom_data to the combinational ROM;
// halt freezes fetch; redirect/redirect_target flush and restart fetch; out_* is the
// valid/ready head entry (zeroed when empty); occupancy is the entry count.
// Optional IFQ_PERF_COUNT_EN adds saturating fetched_count and flush_count outputs.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [63:0]                rom_address,
  input  logic [31:0]                rom_data,
  input  logic                       halt,
  input  logic                       redirect,
  input  logic [63:0]                redirect_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instruction,
  output logic [63:0]                out_pc,
  output logic [63:0]                out_pc4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef IFQ_PERF_COUNT_EN
  ,
  output logic [31:0]                fetched_count,
  output logic [31:0]                flush_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [63:0] pc_q, pc_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0] pc_mem [DEPTH];
  logic [31:0] ins_mem [DEPTH];
  logic pop, push, full;
  assign out_valid = count_q != '0;
  assign full = count_q == CW'(DEPTH);
  assign pop = out_valid & out_ready;
  assign push = ~redirect & ~halt & (~full | pop);
  assign rom_address = pc_q;
  assign occupancy = count_q;
  assign out_pc = out_valid ? pc_mem[head_q] : '0;
  assign out_pc4 = out_valid ? pc_mem[head_q] + 64'd4 : '0;
  assign out_instruction = out_valid ? ins_mem[head_q] : '0;
  always_comb begin
    pc_d = redirect ? (redirect_target & ~64'h3) : push ? pc_q + 64'd4 : pc_q;
    head_d = redirect ? '0 : head_q + AW'(pop);
    tail_d = redirect ? '0 : tail_q + AW'(push);
    count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      pc_q <= pc_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push & ~reset) begin
      pc_mem[tail_q] <= pc_q;
      ins_mem[tail_q] <= rom_data;
    end
  end
`ifdef IFQ_PERF_COUNT_EN
  logic [31:0] fetched_q, flush_q;
  // a flush counts only if something besides the honoured pop is thrown away
  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q <= '0;
      flush_q <= '0;
    end else begin
      if (pop & ~&fetched_q) fetched_q <= fetched_q + 32'd1;
      if (redirect & (count_q > CW'(pop)) & ~&flush_q) flush_q <= flush_q + 32'd1;
    end
  end
  assign fetched_count = fetched_q;
  assign flush_count = flush_q;
`endif
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: vector table plus scoreboard check of the fetch queue
module tb_instruction_fetch_queue;
  logic clock = 1'b0;
  logic reset, halt, redirect, out_ready, out_valid;
  logic [63:0] rom_address, redirect_target, out_pc, out_pc4;
  logic [31:0] rom_data, out_instruction;
  logic [2:0] occupancy;
`ifdef IFQ_PERF_COUNT_EN
  logic [31:0] fetched_count, flush_count;
`endif
  int ntests = 0, nfail = 0;
  logic [63:0] mq[$];
  logic [63:0] mpc;
  longint unsigned mfetch = 0, mflush = 0;
  typedef struct {
    logic r, h, rd;
    logic [63:0] t;
    logic rdy;
    logic ev;
    int eo;
    logic [63:0] epc, erom;
  } vec_t;
  vec_t tv[31];

  always #5 clock = ~clock;
  assign rom_data = 32'(rom_address >> 2);

  instruction_fetch_queue #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .halt(halt), .redirect(redirect), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_pc4(out_pc4), .occupancy(occupancy)
`ifdef IFQ_PERF_COUNT_EN
    , .fetched_count(fetched_count), .flush_count(flush_count)
`endif
  );

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic put(input int i, input logic r, h, rd, input logic [63:0] t, input logic rdy,
                     input logic ev, input int eo, input logic [63:0] epc, erom);
    tv[i] = '{r, h, rd, t, rdy, ev, eo, epc, erom};
  endtask

  task automatic step(input logic r, h, rd, input logic [63:0] t, input logic rdy);
    bit pop, push;
    int sz;
    logic [63:0] e;
    reset = r; halt = h; redirect = rd; redirect_target = t; out_ready = rdy;
    sz = mq.size();
    pop = sz != 0 && rdy;
    push = !rd && !h && (sz < 4 || pop);
    @(posedge clock);
    if (r) begin
      mq.delete(); mpc = 64'h0; mfetch = 0; mflush = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        if (mfetch < 64'hFFFF_FFFF) mfetch++;
      end
      if (rd) begin
        if (sz - int'(pop) > 0 && mflush < 64'hFFFF_FFFF) mflush++;
        mq.delete();
        mpc = t & ~64'h3;
      end else if (push) begin
        mq.push_back(mpc);
        mpc = mpc + 64'd4;
      end
    end
    @(negedge clock);
    chk("sb_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("sb_occ", 64'(occupancy), 64'(mq.size()));
    chk("sb_rom", rom_address, mpc);
    if (mq.size() != 0) begin
      e = mq[0];
      chk("sb_pc", out_pc, e);
      chk("sb_ins", 64'(out_instruction), 64'(32'(e >> 2)));
      chk("sb_pc4", out_pc4, e + 64'd4);
    end else begin
      chk("sb_zero", {out_pc ^ out_pc4, 32'h0, out_instruction} | out_pc4, 64'h0);
    end
`ifdef IFQ_PERF_COUNT_EN
    chk("perf_fetch", 64'(fetched_count), 64'(mfetch));
    chk("perf_flush", 64'(flush_count), 64'(mflush));
`endif
  endtask

  initial begin
    put(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    put(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      put(k + 1, 0, 0, 0, 0, 0, 1, (k < 4) ? k : 4, 0, 64'(4 * ((k < 4) ? k : 4)));
    put(12, 0, 0, 0, 0, 1, 1, 4, 4, 20);
    put(13, 0, 0, 0, 0, 1, 1, 4, 8, 24);
    put(14, 0, 0, 0, 0, 1, 1, 4, 12, 28);
    put(15, 0, 0, 0, 0, 1, 1, 4, 16, 32);
    put(16, 0, 0, 0, 0, 1, 1, 4, 20, 36);
    put(17, 0, 0, 1, 64'h103, 1, 0, 0, 0, 64'h100);
    put(18, 0, 0, 0, 0, 1, 1, 1, 64'h100, 64'h104);
    put(19, 0, 1, 0, 0, 0, 1, 1, 64'h100, 64'h104);
    put(20, 0, 1, 0, 0, 1, 0, 0, 0, 64'h104);
    put(21, 0, 1, 0, 0, 1, 0, 0, 0, 64'h104);
    put(22, 0, 0, 0, 0, 1, 1, 1, 64'h104, 64'h108);
    put(23, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    put(24, 0, 0, 0, 0, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    put(25, 0, 0, 0, 0, 1, 1, 1, 0, 4);
    put(26, 0, 0, 0, 0, 0, 1, 2, 0, 8);
    put(27, 1, 1, 1, 64'h80, 1, 0, 0, 0, 0);
    put(28, 0, 1, 1, 64'h40, 0, 0, 0, 0, 64'h40);
    put(29, 0, 1, 0, 0, 0, 0, 0, 0, 64'h40);
    put(30, 0, 0, 0, 0, 1, 1, 1, 64'h40, 64'h44);
    for (int i = 0; i < 31; i++) begin
      step(tv[i].r, tv[i].h, tv[i].rd, tv[i].t, tv[i].rdy);
      chk($sformatf("tv%0d_valid", i), 64'(out_valid), 64'(tv[i].ev));
      chk($sformatf("tv%0d_occ", i), 64'(occupancy), 64'(tv[i].eo));
      chk($sformatf("tv%0d_pc", i), out_pc, tv[i].epc);
      chk($sformatf("tv%0d_rom", i), rom_address, tv[i].erom);
    end
    // full queue flushed while its head is consumed, then redirect on an empty queue
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("full_occ", 64'(occupancy), 64'd4);
    step(0, 0, 1, 64'h200, 1);
    step(0, 0, 1, 64'h300, 1);
    step(0, 0, 0, 0, 1);
    chk("redir_pc", out_pc, 64'h300);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
           ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))
                                       : {32'($urandom), 32'($urandom)},
           $urandom_range(0, 2) != 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch front end for the LEGv8 single-clock CPU: owns the program counter, reads 32-bit instructions from the combinational instruction ROM, and buffers them with their PC in a small FIFO. It sits directly upstream of the control unit and datapath, handing one instruction per valid/ready handshake. Branch redirects from the status/branch logic flush the queue and restart fetch at the target.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 64'h0, PC loaded on reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- rom_address  output  64  current fetch PC; drives the instruction ROM address.
- rom_data  input  32  instruction at rom_address (combinational ROM, same cycle).
- halt  input  1  suppresses new fetches; queue still drains.
- redirect  input  1  flush queue and restart fetch at redirect_target.
- redirect_target  input  64  new PC; bits [1:0] forced to 0.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer accepts head this cycle.
- out_instruction  output  32  head instruction; 0 when out_valid=0.
- out_pc  output  64  head PC; 0 when out_valid=0.
- out_pc4  output  64  out_pc + 4 (mod 2^64); 0 when out_valid=0.
- occupancy  output  $clog2(DEPTH+1)  number of valid entries.

## Operation
- pop = out_valid & out_ready.
- push = ~reset & ~redirect & ~halt & (occupancy < DEPTH | pop).
- On push: write {PC, rom_data} at tail; PC <= PC + 4, 64-bit wrap (64'hFFFF_FFFF_FFFF_FFFC + 4 = 0).
- On pop: head advances. Push and pop in the same cycle leave occupancy unchanged, including when full.
- redirect: PC <= {redirect_target[63:2], 2'b00}; all entries discarded (occupancy 0 next cycle). A pop in the redirect cycle is honoured (consumer keeps that head); no push that cycle.
- halt: PC holds; pops continue; fetch resumes from the held PC on the first cycle halt is low.
- redirect and halt together: redirect takes effect (PC loads, flush); no fetch while halt remains high.
- Head/tail pointers are log2(DEPTH) bits, wrapping modulo DEPTH; full/empty decided by occupancy, not pointer equality.
- Outputs are registered state (FIFO head) plus output zeroing mux; no combinational path from out_ready or redirect to out_* or rom_address.

## Timing
- Reset (synchronous): PC = RESET_PC, occupancy = 0, out_valid = 0, out_instruction/out_pc/out_pc4 = 0, rom_address = RESET_PC.
- First edge after reset deasserts: entry for RESET_PC pushed; out_valid = 1 from that edge on (1-cycle fetch-to-valid latency).
- Redirect asserted at edge N-1..N: out_valid = 0 after edge N; target instruction valid after edge N+1.
- Sustained throughput: one instruction per cycle when out_ready stays high.
- Reset mid-operation overrides everything: queue flushed, PC reloaded, regardless of redirect/halt/pop.

## Configuration
- IFQ_PERF_COUNT_EN defined: adds outputs fetched_count (32-bit, +1 per pop) and flush_count (32-bit, +1 per redirect cycle that discards ≥1 entry), both saturating at 32'hFFFF_FFFF, cleared by reset.
- Undefined: those ports and counters do not exist; all other behaviour identical.

## Test plan
- Reset with RESET_PC=0, ROM word at address k = k/4, out_ready=1: after reset drops, out_pc sequence 0,4,8,... one per cycle, out_instruction 0,1,2,..., out_pc4 = out_pc+4.
- out_ready=0 for 10 cycles: occupancy rises 1..4 and holds at 4, PC stops at 16; then out_ready=1 gives PCs 0,4,8,12,16,20 contiguous with no gap or duplicate.
- Full queue, redirect with target 0x103 and out_ready=1: head PC 0 consumed that cycle, next cycle out_valid=0, cycle after out_pc=0x100.
- halt=1 for 3 cycles with queue draining: out_valid falls after occupancy reaches 0, PC frozen; halt=0 resumes at the frozen PC with no skipped address.
- Redirect to 64'hFFFF_FFFF_FFFF_FFFC: PCs FFFF_FFFF_FFFF_FFFC then 0; reset asserted mid-burst: next cycle occupancy=0, out_valid=0, rom_address=RESET_PC.
- With IFQ_PERF_COUNT_EN: 5 pops and 2 flushing redirects give fetched_count=5, flush_count=2; redirect on empty queue leaves flush_count unchanged.
